pipe_mux_skid: RTL and testbench

- Parametrised N-input, WIDTH-bit pipeline mux for the datapath. It is the registered successor of the existing 2:1 combinational muxes.
- Selects one of N inputs with S and registers the result into a 2-entry skid buffer with valid/ready handshake on both sides.
- Sits at pipeline-stage boundaries (forwarding/writeback select) where the downstream stage can stall. Supports flush on branch/exception and a sticky out-of-range select flag.

---
 rtl/pipe_mux_skid.sv | 132 +++++++++++++
 tb/tb_pipe_mux_skid.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_skid.sv
// rtl/pipe_mux_skid.sv - registered N:1 select mux feeding a 2-entry skid buffer
//
// Ports:
//   CLK       clock, all state changes on the rising edge
//   Reset     synchronous active-high reset
//   D         N*WIDTH flattened inputs, input i = D[i*WIDTH +: WIDTH]
//   S         select, sampled on an accepted beat
//   InValid   upstream beat present
//   InReady   block can accept a beat (decoded from state and Reset only)
//   Flush     discard all buffered beats
//   Y         registered selected data
//   OutValid  Y holds a valid beat
//   OutReady  downstream consumes Y this cycle
//   SelErr    sticky: an accepted beat had S >= N
module pipe_mux_skid #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]   S,
    input  logic               InValid,
    output logic               InReady,
    input  logic               Flush,
    output logic [WIDTH-1:0]   Y,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               SelErr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] sel;
    logic             sel_oob;
    logic             selerr_q;
    logic             accept;
    logic             load_main_sel;
    logic             load_main_skid;
    logic             load_skid;

    // Explicit compare against every legal index so that non-power-of-2 N
    // and out-of-range selects both resolve to zero without indexing past D.
    always_comb begin
        sel     = '0;
        sel_oob = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (int'(S) == i) begin
                sel     = D[i*WIDTH +: WIDTH];
                sel_oob = 1'b0;
            end
        end
    end

    assign InReady  = !Reset && (state != TWO);
    assign OutValid = (state != EMPTY);
    assign accept   = InValid && InReady;
    assign Y        = main_q;
    assign SelErr   = selerr_q;

    always_comb begin
        state_nxt      = state;
        load_main_sel  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_sel = 1'b1;
                    state_nxt     = ONE;
                end
            end
            ONE: begin
                if (accept && OutReady) begin
                    load_main_sel = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (OutReady) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (OutReady) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush only clears validity; data registers keep their contents.
        if (Flush) begin
            state_nxt      = EMPTY;
            load_main_sel  = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            selerr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_main_sel) begin
                main_q <= sel;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= sel;
            end
            // Flagged even when the same-cycle Flush drops the beat.
            if (accept && sel_oob) begin
                selerr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mux_skid.sv
// tb/tb_pipe_mux_skid.sv - vector table, corner sequences and random model check
module tb_pipe_mux_skid;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [127:0] d4;
    logic [1:0]   S;
    logic         InValid;
    logic         Flush;
    logic         OutReady;
    logic         ir4, ov4, se4;
    logic         ir3, ov3, se3;
    logic [31:0]  y4, y3;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pipe_mux_skid #(.WIDTH(32), .N(4), .SEL_W(2)) dut4 (
        .CLK(CLK), .Reset(Reset), .D(d4), .S(S), .InValid(InValid),
        .InReady(ir4), .Flush(Flush), .Y(y4), .OutValid(ov4),
        .OutReady(OutReady), .SelErr(se4)
    );

    pipe_mux_skid #(.WIDTH(32), .N(3), .SEL_W(2)) dut3 (
        .CLK(CLK), .Reset(Reset), .D(d4[95:0]), .S(S), .InValid(InValid),
        .InReady(ir3), .Flush(Flush), .Y(y3), .OutValid(ov3),
        .OutReady(OutReady), .SelErr(se3)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  s;
        logic        inv;
        logic        flush;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_y;
        logic        e_se;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rst, logic [1:0] s, logic inv, logic flush,
                                logic ordy, logic e_ir, logic e_ov,
                                logic [31:0] e_y, logic e_se);
        vec_t v;
        v.rst = rst; v.s = s; v.inv = inv; v.flush = flush; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_y = e_y; v.e_se = e_se;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] s, input logic inv,
                         input logic flush, input logic ordy);
        Reset = rst; S = s; InValid = inv; Flush = flush; OutReady = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: each instance is a FIFO of at most two beats.
    logic [31:0] mq[2][$];
    logic [31:0] my[2];
    logic        mse[2];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int          n;
            logic        acc;
            logic        xfer;
            logic [31:0] v;
            n = (k == 0) ? 4 : 3;
            if (Reset) begin
                mq[k].delete();
                my[k]  = '0;
                mse[k] = 1'b0;
            end else begin
                acc  = InValid && (mq[k].size() < 2);
                xfer = (mq[k].size() > 0) && OutReady;
                v    = (int'(S) < n) ? d4[int'(S)*32 +: 32] : 32'h0;
                if (acc && int'(S) >= n) mse[k] = 1'b1;
                if (xfer) void'(mq[k].pop_front());
                if (Flush) mq[k].delete();
                else if (acc) mq[k].push_back(v);
                if (mq[k].size() > 0) my[k] = mq[k][0];
            end
        end
    endtask

    initial begin
        Reset = 1'b1; S = '0; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        d4 = {32'h44, 32'h33, 32'h22, 32'h11};
        tick();

        // rst, s, inv, flush, ordy | pre-edge InReady | OutValid, Y, SelErr after edge
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h00, 0));
        tv.push_back(mk(0, 2, 1, 0, 1, 1, 1, 32'h33, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h33, 0));
        tv.push_back(mk(0, 0, 1, 0, 1, 1, 1, 32'h11, 0));
        tv.push_back(mk(0, 1, 1, 0, 1, 1, 1, 32'h22, 0));
        tv.push_back(mk(0, 2, 1, 0, 1, 1, 1, 32'h33, 0));
        tv.push_back(mk(0, 3, 1, 0, 1, 1, 1, 32'h44, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h44, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h11, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 1, 1, 32'h11, 0));
        tv.push_back(mk(0, 2, 1, 0, 0, 0, 1, 32'h11, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h22, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h22, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h11, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 1, 1, 32'h11, 0));
        tv.push_back(mk(0, 2, 1, 1, 0, 0, 0, 32'h11, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h11, 0));
        tv.push_back(mk(0, 2, 1, 0, 0, 1, 1, 32'h33, 0));
        tv.push_back(mk(0, 3, 1, 0, 0, 1, 1, 32'h33, 0));
        tv.push_back(mk(1, 2, 1, 0, 0, 0, 0, 32'h00, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h00, 0));

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].s, tv[i].inv, tv[i].flush, tv[i].ordy);
            chk($sformatf("tv%0d_inready", i), {31'b0, ir4}, {31'b0, tv[i].e_ir});
            tick();
            chk($sformatf("tv%0d_outvalid", i), {31'b0, ov4}, {31'b0, tv[i].e_ov});
            chk($sformatf("tv%0d_y", i), y4, tv[i].e_y);
            chk($sformatf("tv%0d_selerr", i), {31'b0, se4}, {31'b0, tv[i].e_se});
        end

        // N=3 out-of-range select and SelErr stickiness.
        drive(0, 3, 1, 0, 1); tick();
        chk("n3_oob_y", y3, 32'h0);
        chk("n3_oob_valid", {31'b0, ov3}, 32'd1);
        chk("n3_oob_selerr", {31'b0, se3}, 32'd1);
        chk("n4_s3_y", y4, 32'h44);
        chk("n4_s3_selerr", {31'b0, se4}, 32'd0);
        drive(0, 0, 1, 0, 1); tick();
        chk("n3_valid_beat_y", y3, 32'h11);
        chk("n3_sticky_after_beat", {31'b0, se3}, 32'd1);
        drive(0, 1, 1, 1, 1); tick();
        chk("n3_flush_valid", {31'b0, ov3}, 32'd0);
        chk("n3_sticky_after_flush", {31'b0, se3}, 32'd1);
        drive(1, 0, 0, 0, 0); tick();
        chk("n3_reset_selerr", {31'b0, se3}, 32'd0);
        chk("n3_reset_y", y3, 32'h0);

        // Out-of-range accept discarded by Flush still sets SelErr.
        drive(0, 3, 1, 1, 0); tick();
        chk("n3_flush_oob_selerr", {31'b0, se3}, 32'd1);
        chk("n3_flush_oob_valid", {31'b0, ov3}, 32'd0);

        // Randomised run against the FIFO model; starts with a reset cycle.
        for (int c = 0; c < 3000; c++) begin
            d4 = {$urandom, $urandom, $urandom, $urandom};
            drive((c == 0) || ($urandom_range(0, 49) == 0),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 2) != 0));
            if (c > 0) begin
                chk("rnd4_inready", {31'b0, ir4}, {31'b0, !Reset && (mq[0].size() < 2)});
                chk("rnd3_inready", {31'b0, ir3}, {31'b0, !Reset && (mq[1].size() < 2)});
            end
            model_step();
            tick();
            chk("rnd4_outvalid", {31'b0, ov4}, {31'b0, mq[0].size() > 0});
            chk("rnd3_outvalid", {31'b0, ov3}, {31'b0, mq[1].size() > 0});
            chk("rnd4_y", y4, my[0]);
            chk("rnd3_y", y3, my[1]);
            chk("rnd4_selerr", {31'b0, se4}, {31'b0, mse[0]});
            chk("rnd3_selerr", {31'b0, se3}, {31'b0, mse[1]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
